// File: rtl/microseq_ctrl.sv
// Micro-sequencer control: decodes seq_op, condition flags and memory handshake into counter cmd/load_addr.
// Latency: cmd/load_addr/stall are combinational (same cycle); stack, sp, state and fault update on clk rise.
// Backpressure: stall=1 in WAIT (until mem_ready) and in FAULT (until reset); seq_op is ignored while stalled.
//
// Ports:
//   clk, reset (async, active-low)
//   seq_op, cond_sel, seq_target, cond_flags, dispatch_addr, cur_addr, mem_ready  -- inputs
//   cmd (HOLD=0 INC=1 LOAD=2 ZERO=3), load_addr, stall, fault (sticky)          -- outputs
module microseq_ctrl #(
    parameter int AW          = 11,
    parameter int STACK_DEPTH = 4,
    parameter int NCOND       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               seq_op,
    input  logic [$clog2(NCOND)-1:0] cond_sel,
    input  logic [AW-1:0]            seq_target,
    input  logic [NCOND-1:0]         cond_flags,
    input  logic [AW-1:0]            dispatch_addr,
    input  logic [AW-1:0]            cur_addr,
    input  logic                     mem_ready,
    output logic [1:0]               cmd,
    output logic [AW-1:0]            load_addr,
    output logic                     stall,
    output logic                     fault
);

    localparam logic [1:0] CMD_HOLD = 2'd0;
    localparam logic [1:0] CMD_INC  = 2'd1;
    localparam logic [1:0] CMD_LOAD = 2'd2;
    localparam logic [1:0] CMD_ZERO = 2'd3;

    localparam logic [2:0] OP_NEXT     = 3'd0;
    localparam logic [2:0] OP_JUMP     = 3'd1;
    localparam logic [2:0] OP_BR_T     = 3'd2;
    localparam logic [2:0] OP_BR_F     = 3'd3;
    localparam logic [2:0] OP_CALL     = 3'd4;
    localparam logic [2:0] OP_RET      = 3'd5;
    localparam logic [2:0] OP_DISPATCH = 3'd6;
    localparam logic [2:0] OP_WAITMEM  = 3'd7;

    // sp counts 0..STACK_DEPTH, so it needs one more code than the entry index.
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           fault_q, fault_d;
    logic [AW-1:0]  stack_q [STACK_DEPTH];
    logic [AW-1:0]  stack_d [STACK_DEPTH];

    logic [1:0]     cmd_c;
    logic [AW-1:0]  load_addr_c;
    logic           stall_c;

    logic [AW-1:0]  ret_addr;
    logic [SPW-1:0] sp_m1;
    logic [IW-1:0]  push_idx;
    logic [IW-1:0]  pop_idx;

    // Return address wraps silently at 2^AW-1.
    assign ret_addr = cur_addr + AW'(1);
    assign sp_m1    = sp_q - SPW'(1);
    assign push_idx = sp_q[IW-1:0];
    assign pop_idx  = sp_m1[IW-1:0];

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        fault_d     = fault_q;
        stack_d     = stack_q;
        cmd_c       = CMD_HOLD;
        load_addr_c = '0;
        stall_c     = 1'b0;

        case (state_q)
            ST_RUN: begin
                case (seq_op)
                    OP_NEXT: cmd_c = CMD_INC;
                    OP_JUMP: begin
                        cmd_c       = CMD_LOAD;
                        load_addr_c = seq_target;
                    end
                    OP_BR_T, OP_BR_F: begin
                        // BR_T takes the branch on a set flag, BR_F on a clear one.
                        if (cond_flags[cond_sel] == (seq_op == OP_BR_T)) begin
                            cmd_c       = CMD_LOAD;
                            load_addr_c = seq_target;
                        end else begin
                            cmd_c = CMD_INC;
                        end
                    end
                    OP_CALL: begin
                        if (sp_q != SP_FULL) begin
                            stack_d[push_idx] = ret_addr;
                            sp_d              = sp_q + SPW'(1);
                            cmd_c             = CMD_LOAD;
                            load_addr_c       = seq_target;
                        end else begin
                            fault_d = 1'b1;
                            state_d = ST_FAULT;
                        end
                    end
                    OP_RET: begin
                        if (sp_q != '0) begin
                            sp_d        = sp_m1;
                            cmd_c       = CMD_LOAD;
                            load_addr_c = stack_q[pop_idx];
                        end else begin
                            fault_d = 1'b1;
                            state_d = ST_FAULT;
                        end
                    end
                    OP_DISPATCH: begin
                        cmd_c       = CMD_LOAD;
                        load_addr_c = dispatch_addr;
                    end
                    OP_WAITMEM: begin
                        // A ready memory on entry costs no wait state.
                        if (mem_ready) begin
                            cmd_c = CMD_INC;
                        end else begin
                            stall_c = 1'b1;
                            state_d = ST_WAIT;
                        end
                    end
                    default: cmd_c = CMD_HOLD;
                endcase
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    cmd_c   = CMD_INC;
                    state_d = ST_RUN;
                end else begin
                    stall_c = 1'b1;
                end
            end
            ST_FAULT: begin
                stall_c = 1'b1;
            end
            default: begin
                stall_c = 1'b1;
                state_d = ST_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            sp_q    <= '0;
            fault_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            fault_q <= fault_d;
            stack_q <= stack_d;
        end
    end

    // Reset forces the counter to zero combinationally so it clears in step with us.
    assign cmd       = reset ? cmd_c       : CMD_ZERO;
    assign load_addr = reset ? load_addr_c : '0;
    assign stall     = reset ? stall_c     : 1'b0;
    assign fault     = fault_q;

endmodule

// File: tb/tb_microseq_ctrl.sv
// Directed bench for microseq_ctrl with a queue-based scoreboard.
// The driver applies one vector per cycle (#1 after rising edge) and queues its expected outputs.
// The monitor pops one expectation per falling edge and compares cmd/load_addr/stall/fault.
module tb_microseq_ctrl;

    localparam logic [1:0] HOLD = 2'd0;
    localparam logic [1:0] INC  = 2'd1;
    localparam logic [1:0] LOAD = 2'd2;
    localparam logic [1:0] ZERO = 2'd3;

    localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, BR_T = 3'd2, BR_F = 3'd3;
    localparam logic [2:0] CALL = 3'd4, RET = 3'd5, DISP = 3'd6, WMEM = 3'd7;

    // check mask bits: [3]=cmd [2]=load_addr [1]=stall [0]=fault
    localparam logic [3:0] C_ALL = 4'b1111;
    localparam logic [3:0] C_NLA = 4'b1011;
    localparam logic [3:0] C_NST = 4'b1101;

    typedef struct packed {
        logic [3:0]  chk;
        logic [1:0]  cmd;
        logic [10:0] la;
        logic        stall;
        logic        fault;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [2:0]  seq_op;
    logic [3:0]  cond_sel;
    logic [10:0] seq_target;
    logic [15:0] cond_flags;
    logic [10:0] dispatch_addr;
    logic [10:0] cur_addr;
    logic        mem_ready;
    logic [1:0]  cmd;
    logic [10:0] load_addr;
    logic        stall;
    logic        fault;

    exp_t  exp_q [$];
    string name_q [$];
    int    checks   = 0;
    int    failures = 0;

    microseq_ctrl #(.AW(11), .STACK_DEPTH(4), .NCOND(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .seq_op        (seq_op),
        .cond_sel      (cond_sel),
        .seq_target    (seq_target),
        .cond_flags    (cond_flags),
        .dispatch_addr (dispatch_addr),
        .cur_addr      (cur_addr),
        .mem_ready     (mem_ready),
        .cmd           (cmd),
        .load_addr     (load_addr),
        .stall         (stall),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: outputs are valid every cycle, so one expectation is consumed per falling edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e.chk[3]) begin
                    checks++;
                    if (cmd !== e.cmd) begin
                        failures++;
                        $display("FAIL %s cmd got=%0d exp=%0d", nm, cmd, e.cmd);
                    end
                end
                if (e.chk[2]) begin
                    checks++;
                    if (load_addr !== e.la) begin
                        failures++;
                        $display("FAIL %s load_addr got=0x%03h exp=0x%03h", nm, load_addr, e.la);
                    end
                end
                if (e.chk[1]) begin
                    checks++;
                    if (stall !== e.stall) begin
                        failures++;
                        $display("FAIL %s stall got=%0b exp=%0b", nm, stall, e.stall);
                    end
                end
                if (e.chk[0]) begin
                    checks++;
                    if (fault !== e.fault) begin
                        failures++;
                        $display("FAIL %s fault got=%0b exp=%0b", nm, fault, e.fault);
                    end
                end
            end
        end
    end

    // Apply one vector for one cycle and queue what the outputs must be during that cycle.
    // Note: fault is registered, so ef reflects ops issued in earlier cycles.
    task automatic vec(input string nm, input logic rst, input logic [2:0] op,
                       input logic [3:0] sel, input logic [10:0] tgt, input logic [15:0] fl,
                       input logic [10:0] disp, input logic [10:0] cur, input logic mr,
                       input logic [3:0] chk, input logic [1:0] ecmd, input logic [10:0] ela,
                       input logic es, input logic ef);
        exp_t e;
        @(posedge clk);
        #1;
        reset         = rst;
        seq_op        = op;
        cond_sel      = sel;
        seq_target    = tgt;
        cond_flags    = fl;
        dispatch_addr = disp;
        cur_addr      = cur;
        mem_ready     = mr;
        e.chk   = chk;
        e.cmd   = ecmd;
        e.la    = ela;
        e.stall = es;
        e.fault = ef;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic rst_vec(input string nm);
        vec(nm, 1'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            11'($urandom_range(0, 2047)), 16'($urandom), 11'($urandom_range(0, 2047)),
            11'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)),
            C_ALL, ZERO, 11'h000, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; seq_op = NEXT; cond_sel = '0; seq_target = '0;
        cond_flags = '0; dispatch_addr = '0; cur_addr = '0; mem_ready = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) rst_vec("reset_hold");
        vec("next_after_rst", 1, NEXT, 0, 11'h000, 0, 0, 11'h000, 0, C_NLA, INC, 0, 0, 0);

        // Branches, jump, dispatch
        vec("br_t_taken",  1, BR_T, 3, 11'h155, 16'h0008, 0, 11'h001, 0, C_ALL, LOAD, 11'h155, 0, 0);
        vec("br_f_fall",   1, BR_F, 3, 11'h155, 16'h0008, 0, 11'h002, 0, C_NLA, INC, 0, 0, 0);
        vec("br_f_taken",  1, BR_F, 2, 11'h0AA, 16'h0008, 0, 11'h003, 0, C_ALL, LOAD, 11'h0AA, 0, 0);
        vec("br_t_fall",   1, BR_T, 2, 11'h0AA, 16'h0008, 0, 11'h004, 0, C_NLA, INC, 0, 0, 0);
        vec("br_t_bit15",  1, BR_T, 15, 11'h7F0, 16'h8000, 0, 11'h005, 0, C_ALL, LOAD, 11'h7F0, 0, 0);
        vec("jump",        1, JUMP, 0, 11'h3C3, 0, 0, 11'h006, 0, C_ALL, LOAD, 11'h3C3, 0, 0);
        vec("dispatch",    1, DISP, 0, 11'h111, 0, 11'h2A0, 11'h3C3, 0, C_ALL, LOAD, 11'h2A0, 0, 0);

        // Nested call / return
        vec("call1",       1, CALL, 0, 11'h100, 0, 0, 11'h010, 0, C_ALL, LOAD, 11'h100, 0, 0);
        vec("call2",       1, CALL, 0, 11'h200, 0, 0, 11'h105, 0, C_ALL, LOAD, 11'h200, 0, 0);
        vec("disp_in_sub", 1, DISP, 0, 11'h3FF, 0, 11'h050, 11'h200, 0, C_ALL, LOAD, 11'h050, 0, 0);
        vec("ret1",        1, RET,  0, 11'h3FF, 0, 0, 11'h050, 0, C_ALL, LOAD, 11'h106, 0, 0);
        vec("ret2",        1, RET,  0, 11'h3FF, 0, 0, 11'h106, 0, C_ALL, LOAD, 11'h011, 0, 0);
        vec("ret_empty",   1, RET,  0, 11'h3FF, 0, 0, 11'h011, 0, C_NST, HOLD, 0, 0, 0);
        vec("fault_on",    1, NEXT, 0, 0, 0, 0, 11'h011, 0, C_NLA, HOLD, 0, 1, 1);
        vec("fault_jump",  1, JUMP, 0, 11'h123, 0, 0, 11'h011, 1, C_NLA, HOLD, 0, 1, 1);
        rst_vec("reset_clr_fault");

        // Overflow: four calls fill the stack, the fifth faults
        vec("ovf_call1",   1, CALL, 0, 11'h101, 0, 0, 11'h020, 0, C_ALL, LOAD, 11'h101, 0, 0);
        vec("ovf_call2",   1, CALL, 0, 11'h102, 0, 0, 11'h101, 0, C_ALL, LOAD, 11'h102, 0, 0);
        vec("ovf_call3",   1, CALL, 0, 11'h103, 0, 0, 11'h102, 0, C_ALL, LOAD, 11'h103, 0, 0);
        vec("ovf_call4",   1, CALL, 0, 11'h104, 0, 0, 11'h103, 0, C_ALL, LOAD, 11'h104, 0, 0);
        vec("ovf_call5",   1, CALL, 0, 11'h105, 0, 0, 11'h104, 0, C_NST, HOLD, 0, 0, 0);
        vec("ovf_fault",   1, RET,  0, 0, 0, 0, 11'h104, 0, C_NLA, HOLD, 0, 1, 1);
        vec("ovf_persist", 1, WMEM, 0, 0, 0, 0, 11'h104, 1, C_NLA, HOLD, 0, 1, 1);
        rst_vec("reset_after_ovf");

        // Underflow on a fresh stack
        vec("ret_fresh",   1, RET,  0, 0, 0, 0, 11'h000, 0, C_NST, HOLD, 0, 0, 0);
        vec("unf_fault",   1, NEXT, 0, 0, 0, 0, 11'h000, 0, C_NLA, HOLD, 0, 1, 1);
        rst_vec("reset_after_unf");

        // Memory wait: three held cycles, then release; then zero-wait entry
        vec("wait_enter",  1, WMEM, 0, 0, 0, 0, 11'h030, 0, C_NLA, HOLD, 0, 1, 0);
        vec("wait_2",      1, JUMP, 0, 11'h444, 0, 0, 11'h030, 0, C_NLA, HOLD, 0, 1, 0);
        vec("wait_3",      1, CALL, 0, 11'h444, 0, 0, 11'h030, 0, C_NLA, HOLD, 0, 1, 0);
        vec("wait_done",   1, JUMP, 0, 11'h444, 0, 0, 11'h030, 1, C_NLA, INC, 0, 0, 0);
        vec("after_wait",  1, NEXT, 0, 0, 0, 0, 11'h031, 0, C_NLA, INC, 0, 0, 0);
        vec("wait_zero",   1, WMEM, 0, 0, 0, 0, 11'h032, 1, C_NLA, INC, 0, 0, 0);
        vec("after_zero",  1, NEXT, 0, 0, 0, 0, 11'h033, 0, C_NLA, INC, 0, 0, 0);

        // Wrap of return address, then reset mid-wait inside a call
        vec("call_wrap",   1, CALL, 0, 11'h123, 0, 0, 11'h7FF, 0, C_ALL, LOAD, 11'h123, 0, 0);
        vec("ret_wrap",    1, RET,  0, 0, 0, 0, 11'h123, 0, C_ALL, LOAD, 11'h000, 0, 0);
        vec("call_chain",  1, CALL, 0, 11'h400, 0, 0, 11'h010, 0, C_ALL, LOAD, 11'h400, 0, 0);
        vec("wait_in_sub", 1, WMEM, 0, 0, 0, 0, 11'h400, 0, C_NLA, HOLD, 0, 1, 0);
        vec("rst_in_wait", 0, WMEM, 0, 0, 0, 0, 11'h400, 0, C_ALL, ZERO, 11'h000, 0, 0);
        vec("run_after",   1, NEXT, 0, 0, 0, 0, 11'h000, 0, C_ALL, INC, 0, 0, 0);
        vec("sp_zero_ret", 1, RET,  0, 0, 0, 0, 11'h001, 0, C_NST, HOLD, 0, 0, 0);
        vec("sp_zero_flt", 1, NEXT, 0, 0, 0, 0, 11'h001, 0, C_NLA, HOLD, 0, 1, 1);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
